// File: rtl/div_share_ctrl_if.sv
// Handshake and data bundle between two division clients, the shared
// divider datapath and div_share_ctrl.
// Ports: reqN_* request channels, respN_* response channels, div_* divider
//   controls/results, busy status.  slave = controller side, master = environment.
interface div_share_ctrl_if;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_dividend, req0_divisor;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_dividend, req1_divisor;

   logic        resp0_valid, resp0_ready, resp0_err;
   logic [31:0] resp0_quotient, resp0_remainder;
   logic        resp1_valid, resp1_ready, resp1_err;
   logic [31:0] resp1_quotient, resp1_remainder;

   logic [31:0] div_dividend, div_divisor;
   logic        div_reset, div_run, div_ready;
   logic [31:0] div_quotient, div_remainder;

   logic        busy;

   modport slave (
      input  req0_valid, req0_dividend, req0_divisor,
      input  req1_valid, req1_dividend, req1_divisor,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_err, resp0_quotient, resp0_remainder,
      output resp1_valid, resp1_err, resp1_quotient, resp1_remainder,
      input  resp0_ready, resp1_ready,
      output div_dividend, div_divisor, div_reset, div_run,
      input  div_ready, div_quotient, div_remainder,
      output busy
   );

   modport master (
      output req0_valid, req0_dividend, req0_divisor,
      output req1_valid, req1_dividend, req1_divisor,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_err, resp0_quotient, resp0_remainder,
      input  resp1_valid, resp1_err, resp1_quotient, resp1_remainder,
      output resp0_ready, resp1_ready,
      input  div_dividend, div_divisor, div_reset, div_run,
      output div_ready, div_quotient, div_remainder,
      input  busy
   );
endinterface

// File: rtl/div_share_ctrl.sv
// Two-client round-robin sequencer for the shared iterative divider, with a
// run-cycle timeout (TIMEOUT >= 2) that aborts a hung divider.
// Ports: clk, Reset_n (async active-low), bus (div_share_ctrl_if.slave).
// Latency: transfer T, div_reset T+1, div_run from T+2, respN_valid 1 cycle after div_ready.
// Backpressure: one division in flight; requests wait in IDLE until the response is taken.
// Option: define DIV_ZERO_BYPASS_EN to answer divisor-0 requests without the divider.
module div_share_ctrl #(
   parameter int unsigned TIMEOUT = 48
) (
   input  logic             clk,
   input  logic             Reset_n,
   div_share_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  tcnt_q;
   logic           grant_q, last_q;
   logic [31:0]    opa_q, opb_q;
   logic [31:0]    q0_q, r0_q, q1_q, r1_q;
   logic           e0_q, e1_q;

   logic           win0, win1, xfer, zero_byp, done_ok, tmo, resp_hs;
   logic [31:0]    sel_dividend, sel_divisor;
   logic           cap_en, cap_id, cap_e;
   logic [31:0]    cap_q, cap_r;

   // Round-robin: on a tie the client not granted last time wins.
   assign win0 = bus.req0_valid && (!bus.req1_valid || last_q);
   assign win1 = bus.req1_valid && (!bus.req0_valid || !last_q);
   assign xfer = (state_q == IDLE) && (win0 || win1);

   assign sel_dividend = win1 ? bus.req1_dividend : bus.req0_dividend;
   assign sel_divisor  = win1 ? bus.req1_divisor  : bus.req0_divisor;

`ifdef DIV_ZERO_BYPASS_EN
   assign zero_byp = (sel_divisor == 32'd0);
`else
   assign zero_byp = 1'b0;
`endif

   // Success wins over timeout when div_ready lands on the last allowed cycle.
   assign done_ok = (state_q == RUN) && bus.div_ready;
   assign tmo     = (state_q == RUN) && !bus.div_ready && (tcnt_q == CW'(TIMEOUT - 1));
   assign resp_hs = (state_q == RESP) && (grant_q ? bus.resp1_ready : bus.resp0_ready);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      bus.req0_ready   = 1'b0;
      bus.req1_ready   = 1'b0;
      bus.div_reset    = 1'b0;
      bus.div_run      = 1'b0;
      bus.resp0_valid  = 1'b0;
      bus.resp1_valid  = 1'b0;
      bus.busy         = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            bus.req0_ready = win0;
            bus.req1_ready = win1;
            if (xfer) state_d = zero_byp ? RESP : LOAD;
         end
         LOAD: begin
            bus.div_reset = 1'b1;
            state_d       = RUN;
         end
         RUN: begin
            bus.div_run = 1'b1;
            if (done_ok || tmo) state_d = RESP;
         end
         RESP: begin
            bus.resp0_valid = !grant_q;
            bus.resp1_valid = grant_q;
            if (resp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single write port into the per-client response registers.
   always_comb begin
      cap_en = 1'b0;
      cap_id = grant_q;
      cap_q  = 32'd0;
      cap_r  = 32'd0;
      cap_e  = 1'b0;
      if (xfer && zero_byp) begin
         cap_en = 1'b1;
         cap_id = win1;
         cap_q  = 32'hFFFF_FFFF;
         cap_r  = sel_dividend;
      end else if (done_ok) begin
         cap_en = 1'b1;
         cap_q  = bus.div_quotient;
         cap_r  = bus.div_remainder;
      end else if (tmo) begin
         cap_en = 1'b1;
         cap_e  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tcnt_q  <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         q0_q    <= 32'd0;
         r0_q    <= 32'd0;
         e0_q    <= 1'b0;
         q1_q    <= 32'd0;
         r1_q    <= 32'd0;
         e1_q    <= 1'b0;
      end else begin
         if (xfer) begin
            grant_q <= win1;
            last_q  <= win1;
            // Bypassed requests never touch the divider, so its operands stay put.
            if (!zero_byp) begin
               opa_q <= sel_dividend;
               opb_q <= sel_divisor;
            end
         end
         if (state_q == LOAD)     tcnt_q <= '0;
         else if (state_q == RUN) tcnt_q <= tcnt_q + CW'(1);
         if (cap_en) begin
            if (cap_id) begin
               q1_q <= cap_q;
               r1_q <= cap_r;
               e1_q <= cap_e;
            end else begin
               q0_q <= cap_q;
               r0_q <= cap_r;
               e0_q <= cap_e;
            end
         end
      end
   end

   assign bus.div_dividend    = opa_q;
   assign bus.div_divisor     = opb_q;
   assign bus.resp0_quotient  = q0_q;
   assign bus.resp0_remainder = r0_q;
   assign bus.resp0_err       = e0_q;
   assign bus.resp1_quotient  = q1_q;
   assign bus.resp1_remainder = r1_q;
   assign bus.resp1_err       = e1_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic div_hang = 1'b0;
   logic [5:0] dcnt;

   div_share_ctrl_if bus();

   div_share_ctrl #(.TIMEOUT(48)) dut (
      .clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Divider model: finishes on its 32nd div_run cycle unless hung.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             dcnt <= '0;
      else if (bus.div_reset) dcnt <= '0;
      else if (bus.div_run)   dcnt <= dcnt + 6'd1;
   end
   assign bus.div_ready     = bus.div_run && !div_hang && (dcnt == 6'd31);
   assign bus.div_quotient  = (bus.div_divisor == 0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
   assign bus.div_remainder = (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;

   typedef struct {
      int          c;
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rv(input int c);
      return (c == 1) ? bus.resp1_valid : bus.resp0_valid;
   endfunction

   task automatic drive(input int c, input logic v, input logic [31:0] a, input logic [31:0] b);
      if (c == 0) begin
         bus.req0_valid = v; bus.req0_dividend = a; bus.req0_divisor = b;
      end else begin
         bus.req1_valid = v; bus.req1_dividend = a; bus.req1_divisor = b;
      end
   endtask

   // Called in cycle T+1; counts cycles until respN_valid and div_run cycles seen.
   task automatic wait_resp(input int c, output int lat, output int runs);
      lat = 1;
      runs = 0;
      while (!rv(c) && lat < 400) begin
         if (bus.div_run) runs++;
         tick();
         lat++;
      end
      check("resp_wait_bound", 32'(lat < 400), 32'd1);
   endtask

   task automatic check_resp(input int c);
      exp_t e;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("resp_client", 32'(c), 32'(e.c));
      check("resp_q", (c == 1) ? bus.resp1_quotient  : bus.resp0_quotient,  e.q);
      check("resp_r", (c == 1) ? bus.resp1_remainder : bus.resp0_remainder, e.r);
      check("resp_err", 32'((c == 1) ? bus.resp1_err : bus.resp0_err), 32'(e.e));
   endtask

   task automatic handshake(input int c);
      if (c == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
      #1;
      check("exit_no_accept", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      tick();
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      #1;
      check("valid_drop", 32'(rv(c)), 32'd0);
   endtask

   task automatic run_one(input int c, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee,
                          input int eruns, input int elat);
      int lat, runs;
      sb.push_back('{c: c, q: eq, r: er, e: ee});
      drive(c, 1'b1, dvd, dvs);
      #1;
      check("grant_ready", 32'((c == 1) ? bus.req1_ready : bus.req0_ready), 32'd1);
      tick();
      drive(c, 1'b0, 32'd0, 32'd0);
      #1;
      if (eruns > 0) begin
         check("load_pulse", 32'(bus.div_reset), 32'd1);
         check("load_dividend", bus.div_dividend, dvd);
      end
      wait_resp(c, lat, runs);
      check("latency", 32'(lat), 32'(elat));
      check("run_cycles", 32'(runs), 32'(eruns));
      check_resp(c);
      handshake(c);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, runs;
      drive(0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 32'd0, 32'd0);
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;

      // Reset state
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_run", 32'(bus.div_run), 32'd0);
      check("rst_dreset", 32'(bus.div_reset), 32'd0);
      check("rst_rvalid", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
      check("rst_rerr", 32'({bus.resp0_err, bus.resp1_err}), 32'd0);
      check("rst_q0", bus.resp0_quotient, 32'd0);
      check("rst_ddvd", bus.div_dividend, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Tie out of reset: client 0 first, then client 1, then client 0 again
      sb.push_back('{c: 0, q: 32'd100, r: 32'd0, e: 1'b0});
      sb.push_back('{c: 1, q: 32'd2,   r: 32'd1, e: 1'b0});
      drive(0, 1'b1, 32'd1000, 32'd10);
      drive(1, 1'b1, 32'd9, 32'd4);
      #1;
      check("tie_r0", 32'(bus.req0_ready), 32'd1);
      check("tie_r1", 32'(bus.req1_ready), 32'd0);
      tick();
      wait_resp(0, lat, runs);
      check("tie_lat0", 32'(lat), 32'd34);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(bus.resp0_valid), 32'd1);
         check("hold_q", bus.resp0_quotient, sb[0].q);
         check("hold_r", bus.resp0_remainder, sb[0].r);
         check("hold_req1_ready", 32'(bus.req1_ready), 32'd0);
         tick();
      end
      check_resp(0);
      handshake(0);
      check("rr_r1", 32'(bus.req1_ready), 32'd1);
      check("rr_r0", 32'(bus.req0_ready), 32'd0);
      tick();
      wait_resp(1, lat, runs);
      check("tie_lat1", 32'(lat), 32'd34);
      check_resp(1);
      handshake(1);
      check("rr_back_r0", 32'(bus.req0_ready), 32'd1);
      check("rr_back_r1", 32'(bus.req1_ready), 32'd0);
      drive(0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 32'd0, 32'd0);
      tick();

      // Single division on client 0
      run_one(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 34);
      // Client 1 alone
      run_one(1, 32'hDEAD_BEEF, 32'd16, 32'h0DEA_DBEE, 32'hF, 1'b0, 32, 34);

      // Hung divider
      div_hang = 1'b1;
      run_one(0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b1, 48, 50);
      div_hang = 1'b0;

      // Divisor zero
`ifdef DIV_ZERO_BYPASS_EN
      run_one(1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b0, 0, 1);
`else
      run_one(1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b0, 32, 34);
`endif

      // Reset in the 10th RUN cycle
      drive(0, 1'b1, 32'd100, 32'd7);
      tick();
      drive(0, 1'b0, 32'd0, 32'd0);
      tick();
      repeat (9) tick();
      check("mid_run_active", 32'(bus.div_run), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_run", 32'(bus.div_run), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_valid", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_one(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 34);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
